// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the boot loader.
// "slave" is the loader's view; "master" is the source/RAM side.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: fills word-addressed instruction RAM from a byte stream
// (16-bit LE word count, then LE words) and holds the core in reset until done.
//
// state   | meaning
// HDR0    | waiting for count[7:0]
// HDR1    | waiting for count[15:8]; range check on accept
// DATA    | collecting the 4 bytes of the next word
// WRITE   | one-cycle write strobe to RAM
// DONE    | load complete, core released, input ignored
// ERROR   | count too large, stream drained and discarded
module imem_loader #(
    parameter int SIZE = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    imem_loader_if.slave bus,
    output logic         o_cpu_rst_n,
    output logic         o_done,
    output logic         o_error
);

    typedef enum logic [2:0] {
        S_HDR0  = 3'd0,
        S_HDR1  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [31:0] C_SIZE = 32'(SIZE);

    state_t      r_state;
    state_t      w_next;
    logic        r_ready;
    logic        w_ready_next;
    logic        w_accept;
    logic [7:0]  r_cnt_lo;
    logic [15:0] r_count;
    logic [15:0] w_hdr_count;
    logic [31:0] w_hdr_count_ext;
    logic [1:0]  r_idx;
    logic [23:0] r_asm;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] w_addr_inc;

    assign w_accept        = bus.in_valid && r_ready;
    assign w_hdr_count     = {bus.in_data, r_cnt_lo};
    assign w_hdr_count_ext = {16'h0000, w_hdr_count};
    assign w_addr_inc      = r_addr + 32'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_HDR0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HDR0: begin
                if (w_accept) begin
                    w_next = S_HDR1;
                end
            end
            S_HDR1: begin
                if (w_accept) begin
                    if (w_hdr_count == 16'd0) begin
                        w_next = S_DONE;
                    end else if (w_hdr_count_ext > C_SIZE) begin
                        w_next = S_ERROR;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && (r_idx == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_addr_inc == {16'h0000, r_count}) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_DATA;
                end
            end
            S_DONE:  w_next = S_DONE;
            S_ERROR: w_next = S_ERROR;
            default: w_next = S_HDR0;
        endcase
    end

    // Ready is registered from the next state so it reads 0 while in reset.
    assign w_ready_next = (w_next == S_HDR0) || (w_next == S_HDR1) ||
                          (w_next == S_DATA) || (w_next == S_ERROR);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready  <= 1'b0;
            r_cnt_lo <= 8'h00;
            r_count  <= 16'h0000;
            r_idx    <= 2'd0;
            r_asm    <= 24'h000000;
            r_addr   <= 32'h0000_0000;
            r_wdata  <= 32'h0000_0000;
        end else begin
            r_ready <= w_ready_next;
            if (w_accept) begin
                case (r_state)
                    S_HDR0: r_cnt_lo <= bus.in_data;
                    S_HDR1: r_count  <= w_hdr_count;
                    S_DATA: begin
                        r_idx <= r_idx + 2'd1;
                        case (r_idx)
                            2'd0:    r_asm[7:0]   <= bus.in_data;
                            2'd1:    r_asm[15:8]  <= bus.in_data;
                            2'd2:    r_asm[23:16] <= bus.in_data;
                            default: r_wdata      <= {bus.in_data, r_asm};
                        endcase
                    end
                    default: ;
                endcase
            end
            if (r_state == S_WRITE) begin
                r_addr <= w_addr_inc;
            end
        end
    end

    assign bus.in_ready  = r_ready;
    assign bus.mem_we    = (r_state == S_WRITE);
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign o_cpu_rst_n   = (r_state == S_DONE);
    assign o_done        = (r_state == S_DONE);
    assign o_error       = (r_state == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized streams against a queue-based model.
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_rst_n;
    logic done;
    logic error;

    imem_loader_if bus();

    imem_loader #(.SIZE(64)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .o_cpu_rst_n (cpu_rst_n),
        .o_done      (done),
        .o_error     (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic        obs_done[$];
    logic [7:0]  stream_q[$];
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            obs_addr.push_back(bus.mem_addr);
            obs_data.push_back(bus.mem_wdata);
            obs_done.push_back(done);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Header plus random payload; expected words assembled little-endian.
    task automatic gen_load(input int count, input int nwords);
        int b0, b1, b2, b3;
        stream_q.delete();
        exp_q.delete();
        stream_q.push_back(8'(count % 256));
        stream_q.push_back(8'(count / 256));
        for (int i = 0; i < nwords; i++) begin
            b0 = int'($urandom_range(0, 255));
            b1 = int'($urandom_range(0, 255));
            b2 = int'($urandom_range(0, 255));
            b3 = int'($urandom_range(0, 255));
            stream_q.push_back(8'(b0));
            stream_q.push_back(8'(b1));
            stream_q.push_back(8'(b2));
            stream_q.push_back(8'(b3));
            exp_q.push_back(32'(b0 + b1 * 256 + b2 * 65536) + 32'(b3) * 32'd16777216);
        end
    endtask

    task automatic release_reset();
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        repeat (2) @(negedge clk);
        obs_addr.delete();
        obs_data.delete();
        obs_done.delete();
        release_reset();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout: in_ready=%b required 1 within 50 cycles", bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_stream(input int max_gap);
        int gap;
        for (int i = 0; i < stream_q.size(); i++) begin
            send_byte(stream_q[i]);
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            if (gap > 0) begin
                bus.in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 8'hA5;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.mem_we, cpu_rst_n, done, error} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_flags: ready,we,cpu_rst_n,done,error=%b required 00000",
                     {bus.in_ready, bus.mem_we, cpu_rst_n, done, error});
        end
        checks++;
        if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_bus: addr=%h wdata=%h required 0", bus.mem_addr, bus.mem_wdata);
        end
        bus.in_valid = 1'b0;
        release_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        stream_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        send_stream(0);
        repeat (3) @(negedge clk);
        checks++;
        if (obs_addr.size() !== 2) begin
            failures++;
            $display("FAIL basic_write_count: got %0d required 2", obs_addr.size());
        end else begin
            checks++;
            if (obs_addr[0] !== 32'd0 || obs_data[0] !== 32'h0010_0513) begin
                failures++;
                $display("FAIL basic_word0: addr=%0d data=%h required 0/00100513", obs_addr[0], obs_data[0]);
            end
            checks++;
            if (obs_addr[1] !== 32'd1 || obs_data[1] !== 32'h0020_0593) begin
                failures++;
                $display("FAIL basic_word1: addr=%0d data=%h required 1/00200593", obs_addr[1], obs_data[1]);
            end
        end
        checks++;
        if ({done, cpu_rst_n, bus.in_ready, error} !== 4'b1100) begin
            failures++;
            $display("FAIL basic_final: done,cpu_rst_n,ready,error=%b required 1100",
                     {done, cpu_rst_n, bus.in_ready, error});
        end
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h0020_0593 || bus.mem_addr !== 32'd2) begin
            failures++;
            $display("FAIL basic_hold: we=%b wdata=%h addr=%0d required 0/00200593/2",
                     bus.mem_we, bus.mem_wdata, bus.mem_addr);
        end
    endtask

    task automatic test_zero_count();
        apply_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        checks++;
        if (done !== 1'b1 || cpu_rst_n !== 1'b1) begin
            failures++;
            $display("FAIL zero_done_latency: done=%b cpu_rst_n=%b required 1/1", done, cpu_rst_n);
        end
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_addr.size() !== 0 || bus.in_ready !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL zero_after: writes=%0d ready=%b done=%b required 0/0/1",
                     obs_addr.size(), bus.in_ready, done);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_overflow();
        int counts[3];
        counts[0] = 65;
        counts[1] = 256;
        counts[2] = int'($urandom_range(65, 65535));
        for (int t = 0; t < 3; t++) begin
            apply_reset();
            gen_load(counts[t], 2);
            for (int i = 0; i < stream_q.size(); i++) begin
                if (i >= 2) begin
                    checks++;
                    if (bus.in_ready !== 1'b1) begin
                        failures++;
                        $display("FAIL overflow_drain_ready: count=%0d byte=%0d ready=%b required 1",
                                 counts[t], i, bus.in_ready);
                    end
                end
                send_byte(stream_q[i]);
            end
            bus.in_valid = 1'b0;
            repeat (3) @(negedge clk);
            checks++;
            if ({error, cpu_rst_n, done, bus.in_ready} !== 4'b1001 || obs_addr.size() !== 0) begin
                failures++;
                $display("FAIL overflow_state: count=%0d error,cpu_rst_n,done,ready=%b writes=%0d required 1001/0",
                         counts[t], {error, cpu_rst_n, done, bus.in_ready}, obs_addr.size());
            end
        end
    endtask

    task automatic test_throttled();
        int counts[2];
        counts[0] = 64;
        counts[1] = int'($urandom_range(1, 63));
        for (int t = 0; t < 2; t++) begin
            apply_reset();
            gen_load(counts[t], counts[t]);
            send_stream(3);
            repeat (3) @(negedge clk);
            checks++;
            if (obs_addr.size() !== counts[t]) begin
                failures++;
                $display("FAIL throttle_write_count: got %0d required %0d", obs_addr.size(), counts[t]);
            end else begin
                for (int i = 0; i < counts[t]; i++) begin
                    checks++;
                    if (obs_addr[i] !== 32'(i) || obs_data[i] !== exp_q[i] || obs_done[i] !== 1'b0) begin
                        failures++;
                        $display("FAIL throttle_word: idx=%0d addr=%0d data=%h done=%b required %0d/%h/0",
                                 i, obs_addr[i], obs_data[i], obs_done[i], i, exp_q[i]);
                    end
                end
            end
            checks++;
            if (done !== 1'b1 || cpu_rst_n !== 1'b1 || error !== 1'b0) begin
                failures++;
                $display("FAIL throttle_done: done=%b cpu_rst_n=%b error=%b required 1/1/0", done, cpu_rst_n, error);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nwords;
        int idx;
        int cycles;
        int bad;
        logic rdy_q[$];
        logic we_q[$];
        logic exp_rdy[$];
        nwords = int'($urandom_range(3, 6));
        apply_reset();
        gen_load(nwords, nwords);
        exp_rdy.push_back(1'b1);
        exp_rdy.push_back(1'b1);
        for (int w = 0; w < nwords; w++) begin
            for (int k = 0; k < 4; k++) exp_rdy.push_back(1'b1);
            exp_rdy.push_back(1'b0);
        end
        idx = 0;
        cycles = 0;
        bus.in_valid = 1'b1;
        while (idx < stream_q.size() && cycles < 200) begin
            bus.in_data = stream_q[idx];
            rdy_q.push_back(bus.in_ready);
            we_q.push_back(bus.mem_we);
            if (bus.in_ready === 1'b1) idx++;
            @(negedge clk);
            cycles++;
        end
        rdy_q.push_back(bus.in_ready);
        we_q.push_back(bus.mem_we);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (rdy_q.size() !== exp_rdy.size()) begin
            failures++;
            $display("FAIL b2b_cycle_count: got %0d cycles required %0d", rdy_q.size(), exp_rdy.size());
        end else begin
            bad = -1;
            for (int i = 0; i < exp_rdy.size(); i++) begin
                if (bad < 0 && (rdy_q[i] !== exp_rdy[i] || we_q[i] !== !exp_rdy[i])) bad = i;
            end
            checks++;
            if (bad >= 0) begin
                failures++;
                $display("FAIL b2b_ready_pattern: cycle=%0d ready=%b we=%b required ready=%b we=%b",
                         bad, rdy_q[bad], we_q[bad], exp_rdy[bad], !exp_rdy[bad]);
            end
        end
        checks++;
        if (obs_data.size() !== nwords) begin
            failures++;
            $display("FAIL b2b_write_count: got %0d required %0d", obs_data.size(), nwords);
        end else begin
            for (int i = 0; i < nwords; i++) begin
                checks++;
                if (obs_addr[i] !== 32'(i) || obs_data[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL b2b_word: idx=%0d addr=%0d data=%h required %0d/%h",
                             i, obs_addr[i], obs_data[i], i, exp_q[i]);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done: done=%b ready=%b required 1/0", done, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_load();
        apply_reset();
        gen_load(3, 3);
        for (int i = 0; i < 8; i++) send_byte(stream_q[i]);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs_addr.size() !== 1) begin
            failures++;
            $display("FAIL midrst_pre_writes: got %0d required 1", obs_addr.size());
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.mem_we, cpu_rst_n, done, error} !== 5'b00000 ||
            bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin
            failures++;
            $display("FAIL midrst_async: ready,we,cpu_rst_n,done,error=%b addr=%h wdata=%h required 00000/0/0",
                     {bus.in_ready, bus.mem_we, cpu_rst_n, done, error}, bus.mem_addr, bus.mem_wdata);
        end
        obs_addr.delete();
        obs_data.delete();
        obs_done.delete();
        release_reset();
        gen_load(1, 1);
        send_stream(0);
        repeat (3) @(negedge clk);
        checks++;
        if (obs_addr.size() !== 1) begin
            failures++;
            $display("FAIL midrst_reload_count: got %0d required 1", obs_addr.size());
        end else begin
            checks++;
            if (obs_addr[0] !== 32'd0 || obs_data[0] !== exp_q[0]) begin
                failures++;
                $display("FAIL midrst_reload_word: addr=%0d data=%h required 0/%h",
                         obs_addr[0], obs_data[0], exp_q[0]);
            end
        end
        checks++;
        if (done !== 1'b1 || cpu_rst_n !== 1'b1) begin
            failures++;
            $display("FAIL midrst_reload_done: done=%b cpu_rst_n=%b required 1/1", done, cpu_rst_n);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        test_reset();
        test_basic();
        test_zero_count();
        test_overflow();
        test_throttled();
        test_back_to_back();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
